// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Brief    : Double-buffered sprite register file, per-pixel hit test and
//            lowest-index priority select with a two-stage output pipeline.
//            Optional overlap flags are built when SPRITE_COLLISION_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
  parameter int N_SPRITES = 8,
  parameter int ELEMENT_W = 5,
  parameter int ADDR_W    = 10,
  parameter int SIZE_LOG2 = 5,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [10:0]          pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 frame_start,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [10:0]          wr_x,
  input  logic [9:0]           wr_y,
  input  logic [ELEMENT_W-1:0] wr_element,
  input  logic                 wr_visible,
  output logic                 ready,
  output logic [ELEMENT_W-1:0] element,
  output logic [ADDR_W-1:0]    address,
  output logic [N_SPRITES-1:0] collision
);
  localparam int c_SIZE = 1 << SIZE_LOG2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PENDING = 2'd1, S_COMMIT = 2'd2} state_t;

  state_t                 r_state;
  logic                   r_wrReady;
  logic [N_SPRITES-1:0]   r_dirty;
  logic [10:0]            r_shX     [N_SPRITES];
  logic [9:0]             r_shY     [N_SPRITES];
  logic [ELEMENT_W-1:0]   r_shElem  [N_SPRITES];
  logic [N_SPRITES-1:0]   r_shVis;
  logic [10:0]            r_liveX   [N_SPRITES];
  logic [9:0]             r_liveY   [N_SPRITES];
  logic [ELEMENT_W-1:0]   r_liveElem[N_SPRITES];
  logic [N_SPRITES-1:0]   r_liveVis;
  logic                   r_holdValid;
  logic [IDX_W-1:0]       r_holdIdx;
  logic [10:0]            r_holdX;
  logic [9:0]             r_holdY;
  logic [ELEMENT_W-1:0]   r_holdElem;
  logic                   r_holdVis;

  logic                   w_wrFire, w_hold, w_shWr, w_shVis;
  logic [IDX_W-1:0]       w_shIdx;
  logic [10:0]            w_shX;
  logic [9:0]             w_shY;
  logic [ELEMENT_W-1:0]   w_shElem;

  assign wr_ready = r_wrReady;
  assign w_wrFire = wr_valid && r_wrReady;
  // A write racing the commit strobe is parked so the commit sees pre-edge shadow data.
  assign w_hold   = w_wrFire && frame_start && (r_state == S_PENDING);

  always_comb begin
    w_shWr   = w_wrFire && !w_hold;
    w_shIdx  = wr_idx;
    w_shX    = wr_x;
    w_shY    = wr_y;
    w_shElem = wr_element;
    w_shVis  = wr_visible;
    if (r_state == S_COMMIT) begin
      w_shWr   = r_holdValid;
      w_shIdx  = r_holdIdx;
      w_shX    = r_holdX;
      w_shY    = r_holdY;
      w_shElem = r_holdElem;
      w_shVis  = r_holdVis;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wrReady   <= 1'b1;
      r_dirty     <= '0;
      r_shVis     <= '0;
      r_liveVis   <= '0;
      r_holdValid <= 1'b0;
      r_holdIdx   <= '0;
      r_holdX     <= '0;
      r_holdY     <= '0;
      r_holdElem  <= '0;
      r_holdVis   <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        r_shX[i]      <= '0;
        r_shY[i]      <= '0;
        r_shElem[i]   <= '0;
        r_liveX[i]    <= '0;
        r_liveY[i]    <= '0;
        r_liveElem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE:    if (w_wrFire) r_state <= S_PENDING;
        S_PENDING: if (frame_start) begin
                     r_state   <= S_COMMIT;
                     r_wrReady <= 1'b0;
                   end
        S_COMMIT:  begin
                     r_state   <= r_holdValid ? S_PENDING : S_IDLE;
                     r_wrReady <= 1'b1;
                   end
        default:   r_state <= S_IDLE;
      endcase

      if (r_state == S_COMMIT) begin
        for (int i = 0; i < N_SPRITES; i++) begin
          if (r_dirty[i]) begin
            r_liveX[i]    <= r_shX[i];
            r_liveY[i]    <= r_shY[i];
            r_liveElem[i] <= r_shElem[i];
            r_liveVis[i]  <= r_shVis[i];
          end
        end
        r_dirty     <= '0;
        r_holdValid <= 1'b0;
      end

      if (w_hold) begin
        r_holdValid <= 1'b1;
        r_holdIdx   <= wr_idx;
        r_holdX     <= wr_x;
        r_holdY     <= wr_y;
        r_holdElem  <= wr_element;
        r_holdVis   <= wr_visible;
      end

      // Out-of-range indices match no channel and are silently dropped.
      for (int i = 0; i < N_SPRITES; i++) begin
        if (w_shWr && (w_shIdx == IDX_W'(i))) begin
          r_shX[i]    <= w_shX;
          r_shY[i]    <= w_shY;
          r_shElem[i] <= w_shElem;
          r_shVis[i]  <= w_shVis;
          r_dirty[i]  <= 1'b1;
        end
      end
    end
  end

  // Stage 1: per-channel hit test in 12-bit unsigned so edge sprites clip instead of wrapping.
  logic [11:0]          w_px, w_py;
  logic [N_SPRITES-1:0] w_hit;
  logic [SIZE_LOG2-1:0] w_dx [N_SPRITES];
  logic [SIZE_LOG2-1:0] w_dy [N_SPRITES];

  assign w_px = {1'b0, pixel_x};
  assign w_py = {2'b00, pixel_y};

  for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_chan
    logic [11:0] w_x0, w_y0;
    assign w_x0      = {1'b0, r_liveX[gi]};
    assign w_y0      = {2'b00, r_liveY[gi]};
    assign w_hit[gi] = r_liveVis[gi]
                     && (w_px >= w_x0) && (w_px < w_x0 + 12'(c_SIZE))
                     && (w_py >= w_y0) && (w_py < w_y0 + 12'(c_SIZE));
    assign w_dx[gi]  = pixel_x[SIZE_LOG2-1:0] - r_liveX[gi][SIZE_LOG2-1:0];
    assign w_dy[gi]  = pixel_y[SIZE_LOG2-1:0] - r_liveY[gi][SIZE_LOG2-1:0];
  end

  logic [N_SPRITES-1:0] r_hit;
  logic                 r_active;
  logic [SIZE_LOG2-1:0] r_dx   [N_SPRITES];
  logic [SIZE_LOG2-1:0] r_dy   [N_SPRITES];
  logic [ELEMENT_W-1:0] r_elem [N_SPRITES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit    <= '0;
      r_active <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        r_dx[i]   <= '0;
        r_dy[i]   <= '0;
        r_elem[i] <= '0;
      end
    end else begin
      r_hit    <= w_hit;
      r_active <= active;
      for (int i = 0; i < N_SPRITES; i++) begin
        r_dx[i]   <= w_dx[i];
        r_dy[i]   <= w_dy[i];
        r_elem[i] <= r_liveElem[i];
      end
    end
  end

  // Stage 2: descending scan so the lowest hitting index is the last assignment.
  logic                 w_selHit;
  logic [ELEMENT_W-1:0] w_selElem;
  logic [ADDR_W-1:0]    w_selAddr;

  always_comb begin
    w_selHit  = 1'b0;
    w_selElem = '0;
    w_selAddr = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (r_active && r_hit[i]) begin
        w_selHit                     = 1'b1;
        w_selElem                    = r_elem[i];
        w_selAddr[2*SIZE_LOG2-1:0]   = {r_dy[i], r_dx[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready   <= 1'b0;
      element <= '0;
      address <= '0;
    end else begin
      ready   <= w_selHit;
      element <= w_selElem;
      address <= w_selAddr;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [N_SPRITES-1:0] r_collision;
  logic                 w_clearColl, w_multiHit;

  assign w_clearColl = (r_state == S_COMMIT) || ((r_state == S_IDLE) && frame_start);
  assign w_multiHit  = |(r_hit & (r_hit - N_SPRITES'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_collision <= '0;
    end else if (w_clearColl) begin
      r_collision <= '0;
    end else if (r_active && w_multiHit) begin
      r_collision <= r_collision | r_hit;
    end
  end

  assign collision = r_collision;
`else
  assign collision = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// Directed + randomized bench for sprite_compositor against a rule-level reference model.
module tb_sprite_compositor;
  localparam int N  = 8;
  localparam int EW = 5;
  localparam int AW = 10;
  localparam int IW = 4;
  localparam int SZ = 32;

  logic          clk = 1'b0;
  logic          reset, active, frame_start, wr_valid, wr_visible;
  logic [10:0]   pixel_x, wr_x;
  logic [9:0]    pixel_y, wr_y;
  logic [IW-1:0] wr_idx;
  logic [EW-1:0] wr_element;
  logic          wr_ready, ready;
  logic [EW-1:0] element;
  logic [AW-1:0] address;
  logic [N-1:0]  collision;

  always #5 clk = ~clk;

  sprite_compositor #(.N_SPRITES(N), .ELEMENT_W(EW), .ADDR_W(AW), .SIZE_LOG2(5), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_element(wr_element), .wr_visible(wr_visible),
    .ready(ready), .element(element), .address(address), .collision(collision)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: live bank, shadow bank, and a staged commit snapshot.
  int   mX[N], mY[N], mE[N];
  bit   mV[N];
  int   sX[N], sY[N], sE[N];
  bit   sV[N], sD[N];
  int   cX[N], cY[N], cE[N];
  bit   cV[N], cD[N];
  bit   mPending, mInCommit, mReady;
  logic [N-1:0] mColl;

  typedef struct {
    logic          rdy;
    logic [EW-1:0] el;
    logic [AW-1:0] ad;
    logic          act;
    logic [N-1:0]  mask;
  } exp_t;
  exp_t q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nCompared++;
    assert (got === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t zeroExp();
    exp_t e;
    e.rdy = 1'b0; e.el = '0; e.ad = '0; e.act = 1'b0; e.mask = '0;
    return e;
  endfunction

  function automatic exp_t predict(int px, int py, logic act);
    exp_t e;
    bit found;
    e = zeroExp();
    e.act = act;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (mV[i] && px >= mX[i] && px < mX[i] + SZ && py >= mY[i] && py < mY[i] + SZ) begin
        e.mask[i] = 1'b1;
        if (!found && act) begin
          found = 1;
          e.rdy = 1'b1;
          e.el  = EW'(mE[i]);
          e.ad  = AW'((py - mY[i]) * SZ + (px - mX[i]));
        end
      end
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mX[i] = 0; mY[i] = 0; mE[i] = 0; mV[i] = 0;
      sX[i] = 0; sY[i] = 0; sE[i] = 0; sV[i] = 0; sD[i] = 0;
      cX[i] = 0; cY[i] = 0; cE[i] = 0; cV[i] = 0; cD[i] = 0;
    end
    mPending = 0; mInCommit = 0; mReady = 1; mColl = '0;
    q.delete();
    q.push_back(zeroExp());
  endtask

  // One clock: predict for the driven pixel, advance model at the edge, check at the negedge.
  task automatic step();
    bit   fire, clr;
    exp_t e;
    q.push_back(predict(int'(pixel_x), int'(pixel_y), active));
    fire = wr_valid && mReady;
    check("wr_ready", wr_ready, mReady);
    @(posedge clk);
    clr = 0;
    if (mInCommit) begin
      for (int i = 0; i < N; i++)
        if (cD[i]) begin mX[i] = cX[i]; mY[i] = cY[i]; mE[i] = cE[i]; mV[i] = cV[i]; end
      mInCommit = 0;
      clr = 1;
    end else if (frame_start) begin
      if (mPending) begin
        for (int i = 0; i < N; i++) begin
          cX[i] = sX[i]; cY[i] = sY[i]; cE[i] = sE[i]; cV[i] = sV[i]; cD[i] = sD[i]; sD[i] = 0;
        end
        mPending = 0;
        mInCommit = 1;
      end else begin
        clr = 1;
      end
    end
    if (fire) begin
      mPending = 1;
      if (int'(wr_idx) < N) begin
        sX[wr_idx] = int'(wr_x); sY[wr_idx] = int'(wr_y);
        sE[wr_idx] = int'(wr_element); sV[wr_idx] = wr_visible; sD[wr_idx] = 1;
      end
    end
    mReady = !mInCommit;
    e = q.pop_front();
    if (clr) mColl = '0;
`ifdef SPRITE_COLLISION_EN
    else if (e.act && $countones(e.mask) >= 2) mColl = mColl | e.mask;
`endif
    @(negedge clk);
    check("ready", ready, e.rdy);
    check("element", element, e.el);
    check("address", address, e.ad);
    check("collision", collision, mColl);
  endtask

  task automatic drive(int px, int py, logic act);
    pixel_x = 11'(px); pixel_y = 10'(py); active = act;
    step();
  endtask

  task automatic write(int idx, int x, int y, int el, logic vis, logic fs);
    wr_valid = 1'b1; wr_idx = IW'(idx); wr_x = 11'(x); wr_y = 10'(y);
    wr_element = EW'(el); wr_visible = vis; frame_start = fs; active = 1'b0;
    step();
    wr_valid = 1'b0; frame_start = 1'b0;
    if (fs) step();
  endtask

  task automatic frame();
    frame_start = 1'b1; active = 1'b0;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic probe(string tag, int px, int py, logic r, int el, int ad);
    drive(px, py, 1'b1);
    drive(0, 0, 1'b0);
    check({tag, ".ready"}, ready, r);
    check({tag, ".element"}, element, el);
    check({tag, ".address"}, address, ad);
  endtask

  initial begin
    int px, py, ch;
    reset = 1'b0; active = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
    pixel_x = '0; pixel_y = '0; wr_idx = '0; wr_x = '0; wr_y = '0;
    wr_element = '0; wr_visible = 1'b0;
    modelReset();
    @(negedge clk); @(negedge clk);
    check("rst.ready", ready, 0);
    check("rst.element", element, 0);
    check("rst.address", address, 0);
    check("rst.collision", collision, 0);
    check("rst.wr_ready", wr_ready, 1);
    reset = 1'b1;

    // Idle frame: nothing visible anywhere.
    frame();
    for (int k = 0; k < 150; k++) drive($urandom_range(0, 799), $urandom_range(0, 599), 1'b1);

    // Channel 0 is not drawn until committed.
    write(0, 400, 400, 1, 1'b1, 1'b0);
    probe("precommit", 400, 400, 0, 0, 0);
    frame();
    probe("c0.origin", 400, 400, 1, 1, 0);
    probe("c0.corner", 431, 431, 1, 1, 1023);
    probe("c0.right", 432, 400, 0, 0, 0);

    // Overlapping channels 2 and 5: lower index wins.
    write(2, 100, 100, 3, 1'b1, 1'b0);
    write(5, 110, 110, 4, 1'b1, 1'b0);
    frame();
    probe("overlap", 115, 115, 1, 3, (15 << 5) | 15);
`ifdef SPRITE_COLLISION_EN
    check("coll24", collision, 32'h24);
`endif
    for (int k = 0; k < 20; k++) drive(100 + $urandom_range(0, 45), 100 + $urandom_range(0, 45), 1'b1);

    // Screen-edge sprite clips rather than wrapping.
    write(1, 790, 590, 6, 1'b1, 1'b0);
    frame();
    probe("edge", 799, 599, 1, 6, (9 << 5) | 9);
    probe("nowrap", 10, 10, 0, 0, 0);

    // Write racing frame_start: pre-edge value commits now, racing value next frame.
    write(3, 250, 250, 9, 1'b1, 1'b0);
    write(3, 300, 300, 8, 1'b1, 1'b1);
    probe("race.old", 255, 255, 1, 9, (5 << 5) | 5);
    probe("race.notyet", 305, 305, 0, 0, 0);
    frame();
    probe("race.new", 305, 305, 1, 8, (5 << 5) | 5);

    // Randomized traffic, including discarded out-of-range indices.
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        write($urandom_range(0, 15), $urandom_range(0, 2047), $urandom_range(0, 1023),
              $urandom_range(0, 31), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0) frame();
      for (int k = 0; k < 30; k++) begin
        ch = $urandom_range(0, N - 1);
        px = mX[ch] + $urandom_range(0, 40) - 4;
        py = mY[ch] + $urandom_range(0, 40) - 4;
        if (px < 0) px = 0;
        if (px > 2047) px = 2047;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
        drive(px, py, 1'($urandom_range(0, 7) != 0));
      end
    end

    // Mid-frame reset with a pending write clears outputs immediately.
    write(4, 50, 50, 2, 1'b1, 1'b0);
    write(0, 400, 400, 1, 1'b1, 1'b0);
    frame();
    write(4, 60, 60, 7, 1'b1, 1'b0);
    drive(405, 405, 1'b1);
    drive(405, 405, 1'b1);
    drive(405, 405, 1'b1);
    check("prereset.ready", ready, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst.ready", ready, 0);
    check("midrst.element", element, 0);
    check("midrst.address", address, 0);
    check("midrst.collision", collision, 0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    frame();
    probe("postrst.pending", 65, 65, 0, 0, 0);
    probe("postrst.c0", 405, 405, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised sprite layer compositor for the VGA path: holds position, memory element and visibility for `N_SPRITES` sprites in a host-writable register file, performs per-pixel hit testing against the current VGA coordinate, and selects the highest-priority hit (lowest index). It sits between the game logic and the sprite memory/colour stage, producing registered `element`/`address`/`ready` for every active pixel. Position updates are double-buffered and committed only at frame start, so sprites never tear mid-frame.

## Interface

- `N_SPRITES`, 8, number of sprite channels (1–16); index 0 has highest priority
- `ELEMENT_W`, 5, width of memory element id
- `ADDR_W`, 10, sprite memory address width; must be ≥ 2·`SIZE_LOG2`
- `SIZE_LOG2`, 5, sprite edge = 2^`SIZE_LOG2` pixels (square sprites)
- `IDX_W`, 4, width of channel index port; 2^`IDX_W` ≥ `N_SPRITES`
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-low reset
- `active`  in  1  VGA video-enable for current pixel
- `pixel_x`  in  11  current horizontal pixel
- `pixel_y`  in  10  current vertical pixel
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking; commit strobe
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_idx`  in  `IDX_W`  target channel
- `wr_x`  in  11  new top-left x
- `wr_y`  in  10  new top-left y
- `wr_element`  in  `ELEMENT_W`  new element id
- `wr_visible`  in  1  new visibility bit
- `ready`  out  1  registered: a sprite pixel is present
- `element`  out  `ELEMENT_W`  registered element id of winning sprite
- `address`  out  `ADDR_W`  registered address inside sprite
- `collision`  out  `N_SPRITES`  sticky per-sprite overlap flags (`SPRITE_COLLISION_EN` only)

## Operation

- Two register banks per channel: shadow (written by host) and live (used by hit test). Fields: x, y, element, visible.
- Reset: both banks x=0, y=0, element=0, visible=0; `ready`=0, `element`=0, `address`=0, `collision`=0, `wr_ready`=1, FSM in IDLE.
- Writes: accepted handshake updates shadow[`wr_idx`] at the clock edge. `wr_idx` ≥ `N_SPRITES` is accepted and discarded. Per-channel dirty bit set on write.
- FSM: IDLE (no dirty bits) → PENDING on any accepted write; PENDING → COMMIT on `frame_start`; COMMIT (one cycle) copies every dirty shadow entry to live, clears dirty bits, `wr_ready`=0, → IDLE. `frame_start` in IDLE: no copy, stays IDLE.
- Write in the same cycle as `frame_start`: commit copies the pre-edge shadow contents; the new write lands in shadow, sets dirty, and commits at the next `frame_start`.
- Hit test per channel i: visible && `pixel_x` ≥ x && `pixel_x` < x+2^`SIZE_LOG2` && same for y. Comparisons in 12-bit unsigned; sprites extending past screen edge are clipped, no wrap-around.
- dx = `pixel_x`−x, dy = `pixel_y`−y (low `SIZE_LOG2` bits); address = {dy, dx} zero-extended to `ADDR_W`.
- Priority: lowest-index hitting channel wins. No hit or `active`=0 → `ready`=0, `element`=0, `address`=0.

## Timing

- Pipeline stage 1 (posedge): register per-channel hit vector, dx/dy, element, and delayed `active`.
- Stage 2 (posedge): priority select, register outputs.
- Latency: outputs correspond to `pixel_x`/`pixel_y`/`active` sampled two rising edges earlier; downstream compensates by two pixels.
- Live bank changes take effect for pixels sampled from the cycle after COMMIT.
- `reset` assertion mid-frame clears pipeline and outputs immediately (asynchronous), discarding pending shadow writes.

## Configuration

- `SPRITE_COLLISION_EN` defined: in stage 2, if ≥ 2 channels hit on an active pixel, set `collision[i]` for every hitting channel; flags sticky, cleared in COMMIT cycle and also on `frame_start` in IDLE; reset value 0.
- Not defined: no overlap logic; `collision` port driven constant 0.

## Test plan

- Reset then idle frame: `active`=1 sweep → `ready`=0, `element`=0, `address`=0 on all pixels; `wr_ready`=1.
- Write ch0 x=400,y=400,element=1,visible=1; no `frame_start` → still not drawn; after `frame_start`, pixel (400,400) → `ready`=1, `element`=1, `address`=0 two cycles later; (431,431) → `address`=1023; (432,400) → `ready`=0.
- Ch2 at (100,100) elem 3, ch5 at (110,110) elem 4, both visible; pixel (115,115) → `element`=3, `address`={5'd15,5'd15}; with `SPRITE_COLLISION_EN`, `collision`=0x24.
- Ch1 at x=790,y=590: pixel (799,599) → `ready`=1, `address`=(9<<5)|9; no hit at x<32.
- Write coincident with `frame_start` → old value live for next frame, new value live after following `frame_start`; `wr_ready`=0 for exactly the COMMIT cycle.
- `reset` low mid-frame with pending write → outputs 0 same cycle; after release and `frame_start`, pending write not displayed.
